// File: rtl/run_dump_ctrl.sv
// Run/dump controller: enables the CPU for up to END_COUNT cycles, then streams every register out.
// Optional feature macro RUN_DUMP_CHECKSUM_EN adds checksum_o, an XOR of all dumped beats.
module run_dump_ctrl #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned END_COUNT = 100
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              halt_i,
    output logic              cpu_en_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [31:0]       cycle_cnt_o,
`ifdef RUN_DUMP_CHECKSUM_EN
    output logic              done_o,
    output logic [DATA_W-1:0] checksum_o
`else
    output logic              done_o
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StLoad,
        StSend,
        StDone
    } state_e;

    localparam logic [31:0]       LastCycle = 32'(END_COUNT - 1);
    localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(NUM_REGS - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;

    // The read index is the dump index itself, so it is valid throughout LOAD.
    assign rf_addr_o = idx_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cpu_en_o     <= 1'b0;
            dump_valid_o <= 1'b0;
            dump_idx_o   <= '0;
            dump_data_o  <= '0;
            cycle_cnt_o  <= '0;
            done_o       <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_q     <= StRun;
                        cpu_en_o    <= 1'b1;
                        cycle_cnt_o <= '0;
                        idx_q       <= '0;
                        done_o      <= 1'b0;
                    end
                end
                StRun: begin
                    cycle_cnt_o <= cycle_cnt_o + 32'd1;
                    // Halt and terminal count together still give one transition.
                    if (halt_i || (cycle_cnt_o == LastCycle)) begin
                        state_q  <= StLoad;
                        cpu_en_o <= 1'b0;
                    end
                end
                StLoad: begin
                    dump_data_o  <= rf_data_i;
                    dump_idx_o   <= idx_q;
                    dump_valid_o <= 1'b1;
                    state_q      <= StSend;
                end
                StSend: begin
                    if (dump_ready_i) begin
                        dump_valid_o <= 1'b0;
                        if (idx_q == LastIdx) begin
                            state_q <= StDone;
                            done_o  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + ADDR_W'(1);
                            state_q <= StLoad;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef RUN_DUMP_CHECKSUM_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            checksum_o <= '0;
        end else if (((state_q == StIdle) || (state_q == StDone)) && start_i) begin
            checksum_o <= '0;
        end else if ((state_q == StSend) && dump_ready_i) begin
            checksum_o <= checksum_o ^ dump_data_o;
        end
    end
`endif

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Directed bench for run_dump_ctrl: a cycle table for the basic run/dump plus halt, stall,
// mid-dump reset and start-ignore sequences (checksum checks when RUN_DUMP_CHECKSUM_EN is set).
module tb_run_dump_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt;
    logic        cpu_en;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic [31:0] cycle_cnt;
    logic        done;
`ifdef RUN_DUMP_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] regs [0:3];

    int checks   = 0;
    int failures = 0;

    run_dump_ctrl #(
        .DATA_W    (32),
        .NUM_REGS  (4),
        .ADDR_W    (5),
        .END_COUNT (5)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .halt_i       (halt),
        .cpu_en_o     (cpu_en),
        .rf_addr_o    (rf_addr),
        .rf_data_i    (rf_data),
        .dump_valid_o (dump_valid),
        .dump_ready_i (dump_ready),
        .dump_idx_o   (dump_idx),
        .dump_data_o  (dump_data),
        .cycle_cnt_o  (cycle_cnt),
`ifdef RUN_DUMP_CHECKSUM_EN
        .done_o       (done),
        .checksum_o   (checksum)
`else
        .done_o       (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rf_data = '0;
        if (rf_addr < 5'd4) rf_data = regs[rf_addr[1:0]];
    end

    typedef struct {
        logic        start;
        logic        halt;
        logic        ready;
        logic        cpu_en;
        logic        valid;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [31:0] cnt;
        logic        done;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, input logic h, input logic r, input logic c,
                       input logic v, input int i, input int d, input int n, input logic dn);
        vec_t e;
        e.start = s; e.halt = h; e.ready = r; e.cpu_en = c; e.valid = v;
        e.idx = 5'(i); e.data = 32'(d); e.cnt = 32'(n); e.done = dn;
        vq.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " outputs"},
              {cpu_en, dump_valid, done, rf_addr, dump_idx}, '0);
        check({tag, " data"}, {32'd0, dump_data}, '0);
        check({tag, " cnt"}, {32'd0, cycle_cnt}, '0);
`ifdef RUN_DUMP_CHECKSUM_EN
        check({tag, " checksum"}, {32'd0, checksum}, '0);
`endif
    endtask

    // Pulse start, then count RUN cycles; halt is raised during RUN cycle halt_cycle (0 = never).
    task automatic run_phase(input int halt_cycle, output int cpu_cycles);
        int cyc = 0;
        cpu_cycles = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start clears done", {63'd0, done}, 64'd0);
        check("start clears cnt", {32'd0, cycle_cnt}, 64'd0);
        while (cpu_en && cyc < 50) begin
            cpu_cycles++;
            halt = (cpu_cycles == halt_cycle);
            step();
            cyc++;
        end
        halt = 1'b0;
    endtask

    // Drain the dump, checking beat order/content; optionally stall beat stall_idx for 3 cycles.
    task automatic dump_phase(input int stall_idx, input logic start_hold);
        int beat = 0;
        int stalls = 0;
        int cyc = 0;
        start = start_hold;
        while (!done && cyc < 80) begin
            if (start_hold) check("start ignored in dump", {63'd0, cpu_en}, 64'd0);
            if (dump_valid) begin
                if (beat == stall_idx && stalls < 3) begin
                    dump_ready = 1'b0;
                    check($sformatf("stall %0d hold", stalls),
                          {31'd0, dump_valid, dump_idx, dump_data},
                          {31'd0, 1'b1, 5'(stall_idx), regs[stall_idx & 3]});
                    stalls++;
                end else begin
                    dump_ready = 1'b1;
                    check($sformatf("beat %0d", beat), {27'd0, dump_idx, dump_data},
                          {27'd0, 5'(beat), regs[beat & 3]});
                    beat++;
                end
            end else begin
                dump_ready = 1'b1;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        dump_ready = 1'b1;
        check("dump reached done", {63'd0, done}, 64'd1);
        check("beat count", 64'(beat), 64'd4);
        if (stall_idx >= 0) check("stall cycles", 64'(stalls), 64'd3);
    endtask

    initial begin
        int cc;
        int n;
        for (int i = 0; i < 4; i++) regs[i] = 32'(10 + i);
        rst = 1'b0; start = 1'b0; halt = 1'b0; dump_ready = 1'b0;
        #12;
        check_all_zero("reset");
        #1 rst = 1'b1;
        step();
        step();
        check_all_zero("idle hold");

        // Basic run to terminal count, dump with ready always high.
        add(1, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 1, 1, 0, 0, 0, 2, 0);
        add(0, 0, 1, 1, 0, 0, 0, 3, 0);
        add(0, 0, 1, 1, 0, 0, 0, 4, 0);
        add(0, 0, 1, 0, 0, 0, 0, 5, 0);
        add(0, 0, 1, 0, 1, 0, 10, 5, 0);
        add(0, 0, 1, 0, 0, 0, 10, 5, 0);
        add(0, 0, 1, 0, 1, 1, 11, 5, 0);
        add(0, 0, 1, 0, 0, 1, 11, 5, 0);
        add(0, 0, 1, 0, 1, 2, 12, 5, 0);
        add(0, 0, 1, 0, 0, 2, 12, 5, 0);
        add(0, 0, 1, 0, 1, 3, 13, 5, 0);
        add(0, 0, 1, 0, 0, 3, 13, 5, 1);
        add(0, 1, 1, 0, 0, 3, 13, 5, 1);
        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].start; halt = vq[i].halt; dump_ready = vq[i].ready;
            step();
            check($sformatf("vec%0d ctl", i), {61'd0, cpu_en, dump_valid, done},
                  {61'd0, vq[i].cpu_en, vq[i].valid, vq[i].done});
            check($sformatf("vec%0d idx", i), {59'd0, dump_idx}, {59'd0, vq[i].idx});
            check($sformatf("vec%0d data", i), {32'd0, dump_data}, {32'd0, vq[i].data});
            check($sformatf("vec%0d cnt", i), {32'd0, cycle_cnt}, {32'd0, vq[i].cnt});
        end
        halt = 1'b0;
`ifdef RUN_DUMP_CHECKSUM_EN
        check("checksum 10..13", {32'd0, checksum}, 64'd0);
`endif

        // Early halt during the 2nd RUN cycle.
        run_phase(2, cc);
        check("halt2 cpu cycles", 64'(cc), 64'd2);
        check("halt2 cnt", {32'd0, cycle_cnt}, 64'd2);
        dump_phase(-1, 1'b0);
        check("halt2 done cnt", {32'd0, cycle_cnt}, 64'd2);

        // Backpressure on beat 1.
        run_phase(0, cc);
        check("stall run cycles", 64'(cc), 64'd5);
        dump_phase(1, 1'b0);

        // Halt coinciding with terminal count, start held during the dump.
        run_phase(5, cc);
        check("halt5 cpu cycles", 64'(cc), 64'd5);
        check("halt5 cnt", {32'd0, cycle_cnt}, 64'd5);
        check("halt5 in load", {62'd0, cpu_en, dump_valid}, 64'd0);
        step();
        check("halt5 first beat", {26'd0, dump_valid, dump_idx, dump_data},
              {26'd0, 1'b1, 5'd0, 32'd10});
        dump_phase(-1, 1'b1);
        step();
        step();
        check("done holds cnt", {31'd0, done, cycle_cnt}, {31'd0, 1'b1, 32'd5});

        // Asynchronous reset while beat 2 is being offered.
        run_phase(0, cc);
        n = 0;
        while (!(dump_valid && dump_idx == 5'd2) && n < 30) begin
            dump_ready = 1'b1;
            step();
            n++;
        end
        check("reached beat2", {63'd0, dump_valid}, 64'd1);
        #2 rst = 1'b0;
        #1;
        check_all_zero("async reset");
        step();
        #2 rst = 1'b1;
        step();
        step();
        check_all_zero("post reset idle");
        run_phase(0, cc);
        check("fresh run cycles", 64'(cc), 64'd5);
        dump_phase(-1, 1'b0);
        check("fresh run cnt", {32'd0, cycle_cnt}, 64'd5);

`ifdef RUN_DUMP_CHECKSUM_EN
        for (int i = 0; i < 4; i++) regs[i] = 32'(i + 1);
        run_phase(0, cc);
        dump_phase(-1, 1'b0);
        check("checksum 1..4", {32'd0, checksum}, 64'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_dump_ctrl.md
RUN_DUMP_CTRL -- requirements
Module: run_dump_ctrl

Interface
- REQ-001 SHALL have parameter DATA_W, default 32, register data width.
- REQ-002 SHALL have parameter NUM_REGS, default 32, number of registers dumped (>=1).
- REQ-003 SHALL have parameter ADDR_W, default 5, register index width (2**ADDR_W >= NUM_REGS).
- REQ-004 SHALL have parameter END_COUNT, default 100, maximum run cycles before dump (>=1).
- REQ-005 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
- REQ-006 SHALL have port rst_i, input, 1; reset is asynchronous and active-low.
- REQ-007 SHALL have port start_i, input, 1, begins a run from IDLE or DONE.
- REQ-008 SHALL have port halt_i, input, 1, ends a run early.
- REQ-009 SHALL have port cpu_en_o, output, 1, enables the CPU during RUN.
- REQ-010 SHALL have port rf_addr_o, output, ADDR_W, register-file read index.
- REQ-011 SHALL have port rf_data_i, input, DATA_W, combinational register-file read data for rf_addr_o.
- REQ-012 SHALL have port dump_valid_o, output, 1, dump beat valid.
- REQ-013 SHALL have port dump_ready_i, input, 1, dump sink ready.
- REQ-014 SHALL have port dump_idx_o, output, ADDR_W, register index of the current beat.
- REQ-015 SHALL have port dump_data_o, output, DATA_W, register value of the current beat.
- REQ-016 SHALL have port cycle_cnt_o, output, 32, RUN cycles elapsed in the current or last run.
- REQ-017 SHALL have port done_o, output, 1, dump complete.

Function
- REQ-018 SHALL implement states IDLE, RUN, LOAD, SEND, DONE.
- REQ-019 In IDLE or DONE, start_i=1 SHALL enter RUN with cycle_cnt_o=0 and dump index=0; done_o clears.
- REQ-020 In RUN, cpu_en_o SHALL be 1, and 0 in every other state.
- REQ-021 Each RUN cycle SHALL increment cycle_cnt_o by 1, so the final value equals the number of RUN cycles.
- REQ-022 RUN SHALL go to LOAD after the cycle where cycle_cnt_o==END_COUNT-1 or halt_i=1; both at once SHALL cause a single transition.
- REQ-023 In LOAD, rf_addr_o SHALL equal the dump index; rf_data_i SHALL be captured into dump_data_o and the index into dump_idx_o; next state SEND.
- REQ-024 In SEND, dump_valid_o SHALL be 1, with dump_data_o and dump_idx_o held stable until dump_valid_o && dump_ready_i.
- REQ-025 On handshake with index==NUM_REGS-1 SHALL go to DONE; otherwise index+1 and go to LOAD. Minimum is 2 cycles per beat.
- REQ-026 In DONE, done_o SHALL be 1 and cycle_cnt_o SHALL hold its value.
- REQ-027 start_i SHALL be ignored in RUN, LOAD and SEND; halt_i SHALL be ignored outside RUN.
- REQ-028 dump_ready_i SHALL be ignored outside SEND.

Reset
- REQ-029 rst_i=0 SHALL immediately force IDLE with all outputs 0 and the dump index 0, including mid-run or mid-dump.
- REQ-030 After rst_i deasserts, the block SHALL stay in IDLE until start_i.

Configuration
- REQ-031 With RUN_DUMP_CHECKSUM_EN defined, there SHALL be an output checksum_o, DATA_W wide.
  - Cleared on entering RUN and on reset.
  - XOR-accumulates dump_data_o on each handshake.
  - Final value is stable in DONE.
- REQ-032 Without RUN_DUMP_CHECKSUM_EN, checksum_o and its logic SHALL be absent.

Verification (NUM_REGS=4, END_COUNT=5, DATA_W=32, register i holds 10+i)
- REQ-033 Reset, then start_i pulse, dump_ready_i=1:
  - cpu_en_o high exactly 5 cycles.
  - Beats (0,10) (1,11) (2,12) (3,13).
  - done_o=1 with cycle_cnt_o=5.
- REQ-034 Start, then halt_i=1 on the 2nd RUN cycle:
  - cpu_en_o high 2 cycles; cycle_cnt_o=2.
  - 4 beats, then done_o=1.
- REQ-035 dump_ready_i=0 for 3 cycles during beat 1:
  - dump_valid_o stays 1.
  - dump_data_o=11 and dump_idx_o=1 stable for all 3 cycles.
  - No beat lost or duplicated.
- REQ-036 rst_i=0 asserted asynchronously in SEND at beat 2:
  - All outputs 0 immediately; state IDLE.
  - A following start_i gives a full fresh run from index 0.
- REQ-037 halt_i=1 on the 5th (terminal) RUN cycle:
  - One transition to LOAD; cycle_cnt_o=5.
  - start_i held high during the dump has no effect.
- REQ-038 With RUN_DUMP_CHECKSUM_EN defined, REQ-033 stimulus:
  - checksum_o=10^11^12^13=0x00000000 in DONE.
  - With registers 1,2,3,4, checksum_o=0x00000004.
